// File: rtl/load_store_unit.sv
// load_store_unit
//   Sits between the execute stage and the data memory. It accepts one load
//   or store at a time, turns funct3 and the low address bits into byte-lane
//   write strobes and a replicated write word, issues one word-aligned memory
//   access, and returns the sign- or zero-extended load lane. Misaligned or
//   illegal-width requests are answered with an error and never touch memory.
//
// Ports
//   clk, reset           rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake (ready only while idle)
//   req_we               1 = store, 0 = load
//   req_funct3           instruction bits 14:12 (access width / signedness)
//   req_addr             byte address from the ALU; upper bits are ignored
//   req_wdata            store data (rs2)
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata            extended load data, 0 for stores and errors
//   rsp_err              misaligned or illegal funct3
//   mem_addr             word-aligned data-memory byte address
//   mem_wdata            lane-replicated write data
//   mem_wr               byte write strobes
//   mem_re               read strobe; mem_rdata is valid one cycle later
//   mem_rdata            memory read word

module load_store_unit #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [3:0]            mem_wr,
  output logic                  mem_re,
  input  logic [DATA_W-1:0]     mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    CAPTURE,
    RESP
  } state_t;

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            offset_q, offset_d;
  logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DM_ADDRESS-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic [3:0]            mem_wr_q, mem_wr_d;
  logic                  mem_re_q, mem_re_d;

  logic                  req_legal;
  logic                  req_aligned;
  logic [3:0]            req_strobe;
  logic [DATA_W-1:0]     req_repl;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [DATA_W-1:0]     rd_ext;

  // Address bits above the data-memory window wrap away by design.
  logic                  unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:DM_ADDRESS];

  // Decode the incoming request: legality, alignment, strobes and the
  // replicated write word are all launched on the accepting edge.
  always_comb begin
    req_legal   = 1'b0;
    req_aligned = 1'b0;
    req_strobe  = 4'b1111;
    req_repl    = req_wdata;

    if (req_we) begin
      req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                  (req_funct3 == 3'b010);
    end else begin
      req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                  (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                  (req_funct3 == 3'b101);
    end

    case (req_funct3[1:0])
      2'b00: begin
        req_aligned = 1'b1;
        req_strobe  = 4'b0001 << req_addr[1:0];
        req_repl    = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_aligned = ~req_addr[0];
        req_strobe  = req_addr[1] ? 4'b1100 : 4'b0011;
        req_repl    = {2{req_wdata[15:0]}};
      end
      default: begin
        req_aligned = (req_addr[1:0] == 2'b00);
        req_strobe  = 4'b1111;
        req_repl    = req_wdata;
      end
    endcase
  end

  // Pick the returned lane and extend it according to the latched funct3.
  always_comb begin
    rd_byte = mem_rdata[7:0];
    rd_half = offset_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    rd_ext  = mem_rdata;

    case (offset_q)
      2'b00:   rd_byte = mem_rdata[7:0];
      2'b01:   rd_byte = mem_rdata[15:8];
      2'b10:   rd_byte = mem_rdata[23:16];
      default: rd_byte = mem_rdata[31:24];
    endcase

    case (funct3_q)
      3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
      3'b100:  rd_ext = {24'd0, rd_byte};
      3'b101:  rd_ext = {16'd0, rd_half};
      default: rd_ext = mem_rdata;
    endcase
  end

  // Next-state and registered-output logic. Memory strobes are pulses that
  // are only ever set on the transition into ACCESS, so they last one cycle.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    offset_d    = offset_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wr_d    = 4'b0000;
    mem_re_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d        = req_we;
          funct3_d    = req_funct3;
          offset_d    = req_addr[1:0];
          rsp_rdata_d = '0;
          if (req_legal && req_aligned) begin
            state_d     = ACCESS;
            rsp_err_d   = 1'b0;
            mem_addr_d  = {req_addr[DM_ADDRESS-1:2], 2'b00};
            mem_wdata_d = req_repl;
            mem_wr_d    = req_we ? req_strobe : 4'b0000;
            mem_re_d    = ~req_we;
          end else begin
            state_d   = RESP;
            rsp_err_d = 1'b1;
          end
        end
      end
      ACCESS: begin
        state_d = we_q ? RESP : CAPTURE;
      end
      CAPTURE: begin
        rsp_rdata_d = rd_ext;
        state_d     = RESP;
      end
      default: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      offset_q    <= 2'b00;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wr_q    <= 4'b0000;
      mem_re_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      offset_q    <= offset_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wr_q    <= mem_wr_d;
      mem_re_q    <= mem_re_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wr    = mem_wr_q;
  assign mem_re    = mem_re_q;

endmodule
